// File: rtl/apu_issue_ctrl.sv
// apu_issue_ctrl: core-side APU initiator with tag scoreboard, ID-matched writeback and sticky fflags
module apu_issue_ctrl #(
  parameter int NB_ARGS         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int ID_WIDTH        = 9,
  parameter int NB_OUTSTANDING  = 4,
  parameter int REG_ADDR_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] issue_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       issue_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     issue_flags_i,
  input  logic [REG_ADDR_WIDTH-1:0]     issue_rd_i,
  output logic                          apu_req_o,
  input  logic                          apu_gnt_i,
  output logic [ID_WIDTH-1:0]           apu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
  output logic [OPCODE_WIDTH-1:0]       apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
  output logic                          apu_rready_o,
  input  logic                          apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
  input  logic [ID_WIDTH-1:0]           apu_rID_i,
  output logic                          wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0]     wb_rd_o,
  output logic [DATA_WIDTH-1:0]         wb_data_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    wb_flags_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    fflags_o,
  input  logic                          fflags_clr_i,
  output logic                          spurious_o,
  output logic                          busy_o
);
  localparam int SLOT_W = $clog2(NB_OUTSTANDING);
  typedef enum logic {EMPTY, PENDING} req_state_e;
  req_state_e state_q, state_d;
  logic [NB_OUTSTANDING-1:0] valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [NB_OUTSTANDING];
  logic [ID_WIDTH-1:0] id_q;
  logic [NB_ARGS*DATA_WIDTH-1:0] operands_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [FLAGS_IN_WIDTH-1:0] flags_q;
  logic wb_valid_q, spurious_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [FLAGS_OUT_WIDTH-1:0] wb_flags_q, fflags_q, fflags_d;
  logic [SLOT_W-1:0] alloc_idx, rsp_idx;
  logic free_avail, waw, accept, rsp_tag_ok, rsp_hit;
  // Lowest free slot and write-after-write hazard against every pending destination
  always_comb begin
    alloc_idx = '0;
    waw = 1'b0;
    for (int i = NB_OUTSTANDING - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = SLOT_W'(i);
      if (valid_q[i] && rd_q[i] == issue_rd_i) waw = 1'b1;
    end
  end
  assign free_avail    = ~&valid_q;
  assign issue_ready_o = rst_n & ((state_q == EMPTY) | apu_gnt_i) & free_avail & ~waw;
  assign accept        = issue_valid_i & issue_ready_o;
  assign rsp_idx       = apu_rID_i[SLOT_W-1:0];
  assign rsp_tag_ok    = (apu_rID_i >> SLOT_W) == '0;
  assign rsp_hit       = apu_rvalid_i & rsp_tag_ok & valid_q[rsp_idx];
  // Request register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // A new acceptance always refills the register; a grant without refill empties it
  always_comb begin
    state_d = accept ? PENDING : (state_q == PENDING && apu_gnt_i) ? EMPTY : state_q;
  end
  // Request strobe decoded from the register state
  always_comb begin
    apu_req_o = state_q == PENDING;
  end
  // Request payload, held stable until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      operands_q <= '0;
      op_q       <= '0;
      flags_q    <= '0;
    end else if (accept) begin
      id_q       <= ID_WIDTH'(alloc_idx);
      operands_q <= issue_operands_i;
      op_q       <= issue_op_i;
      flags_q    <= issue_flags_i;
    end
  end
  // Release on a matching response and allocate on acceptance; allocation only sees free slots so the two never collide
  always_comb begin
    valid_d = valid_q;
    if (rsp_hit) valid_d[rsp_idx] = 1'b0;
    if (accept) valid_d[alloc_idx] = 1'b1;
  end
  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NB_OUTSTANDING; i++) rd_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) rd_q[alloc_idx] <= issue_rd_i;
    end
  end
  // Sticky status: a clear drops history but keeps the flags of a coincident writeback
  always_comb begin
    fflags_d = (fflags_clr_i ? '0 : fflags_q) | (rsp_hit ? apu_rflags_i : '0);
  end
  // Registered writeback, spurious pulse and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      spurious_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      fflags_q   <= '0;
    end else begin
      wb_valid_q <= rsp_hit;
      spurious_q <= apu_rvalid_i & ~rsp_hit;
      fflags_q   <= fflags_d;
      if (rsp_hit) begin
        wb_rd_q    <= rd_q[rsp_idx];
        wb_data_q  <= apu_rdata_i;
        wb_flags_q <= apu_rflags_i;
      end
    end
  end
  assign apu_ID_o       = id_q;
  assign apu_operands_o = operands_q;
  assign apu_op_o       = op_q;
  assign apu_flags_o    = flags_q;
  assign apu_rready_o   = 1'b1;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign wb_flags_o     = wb_flags_q;
  assign fflags_o       = fflags_q;
  assign spurious_o     = spurious_q;
  assign busy_o         = (state_q == PENDING) | (|valid_q);
endmodule
